// File: rtl/fu_wb_serializer.sv
// ---------------------------------------------------------------------------
// fu_wb_serializer
//
// Buffers multi-result functional-unit output bundles and serialises them onto
// a single register-file write port, one write per cycle. Writes within a
// bundle are issued in ascending slot order. A one-cycle done pulse is sent to
// the ROB when a bundle has been fully written. A bundle with no valid slots
// still completes, one cycle after it reaches the head.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps valid and its payload
// stable until that edge. wb_valid never depends on wb_ready.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   in_valid       FU output bundle valid
//   in_inst_id     completing instruction ID
//   in_prn         destination PRN per slot
//   in_data        64-bit result per slot
//   in_slot_valid  per-slot write enable
//   in_ready       bundle accepted when in_valid && in_ready
//   wb_valid       register-file write request
//   wb_prn         write PRN (0 while wb_valid is low)
//   wb_data        write data (0 while wb_valid is low)
//   wb_ready       register-file write port grant
//   done_valid     one-cycle completion pulse
//   done_inst_id   ID of the completed instruction
// ---------------------------------------------------------------------------
module fu_wb_serializer #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int DEPTH        = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    input  logic [INST_ID_BITS-1:0]                 in_inst_id,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_prn,
    input  logic [MAX_OPERANDS-1:0][63:0]           in_data,
    input  logic [MAX_OPERANDS-1:0]                 in_slot_valid,
    output logic                                    in_ready,
    output logic                                    wb_valid,
    output logic [PRN_BITS-1:0]                     wb_prn,
    output logic [63:0]                             wb_data,
    input  logic                                    wb_ready,
    output logic                                    done_valid,
    output logic [INST_ID_BITS-1:0]                 done_inst_id
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SEL_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    // Bundle storage. Payload is not reset; the masks and count decide what
    // is live, so stale payload is never observed.
    logic [INST_ID_BITS-1:0]               id_mem   [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_mem  [DEPTH];
    logic [MAX_OPERANDS-1:0][63:0]         data_mem [DEPTH];
    logic [MAX_OPERANDS-1:0]               mask_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    // Low during reset and until the first edge after it, so in_ready is
    // a pure function of registered state.
    logic ready_q;

    logic                    push;
    logic                    pop;
    logic                    head_live;
    logic [MAX_OPERANDS-1:0] head_mask;
    logic [MAX_OPERANDS-1:0] sel_onehot;
    logic [SEL_W-1:0]        sel_idx;
    logic                    sel_found;
    logic                    wb_fire;
    logic [MAX_OPERANDS-1:0] mask_after;

    assign in_ready  = ready_q && (count < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign head_live = (count != '0);
    assign head_mask = mask_mem[rd_ptr];

    // Lowest-index pending slot of the head bundle.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_found  = 1'b0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (!sel_found && head_mask[i]) begin
                sel_found     = 1'b1;
                sel_onehot[i] = 1'b1;
                sel_idx       = SEL_W'(i);
            end
        end
    end

    assign wb_valid = head_live && (head_mask != '0);
    assign wb_fire  = wb_valid && wb_ready;

    always_comb begin
        wb_prn  = '0;
        wb_data = '0;
        if (wb_valid) begin
            wb_prn  = prn_mem[rd_ptr][sel_idx];
            wb_data = data_mem[rd_ptr][sel_idx];
        end
    end

    // Mask the head will hold after this edge; the head pops when it is
    // empty, which covers both the last write and a zero-write bundle.
    assign mask_after = wb_fire ? (head_mask & ~sel_onehot) : head_mask;
    assign pop        = head_live && (mask_after == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q      <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            done_valid   <= 1'b0;
            done_inst_id <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_mem[i] <= '0;
            end
        end else begin
            ready_q    <= 1'b1;
            done_valid <= pop;
            if (pop) begin
                done_inst_id <= id_mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // wr_ptr == rd_ptr with a push means the FIFO is empty, so no
            // write handshake can target the same entry in that cycle.
            if (wb_fire) begin
                mask_mem[rd_ptr] <= mask_after;
            end
            if (push) begin
                mask_mem[wr_ptr] <= in_slot_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]   <= in_inst_id;
            prn_mem[wr_ptr]  <= in_prn;
            data_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_fu_wb_serializer.sv
// ---------------------------------------------------------------------------
// tb_fu_wb_serializer
//
// Directed bench for fu_wb_serializer. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A monitor checks every
// write handshake and done pulse against expected queues filled by the
// directed sequences.
// ---------------------------------------------------------------------------
module tb_fu_wb_serializer;

    localparam int IDW = 6;
    localparam int PW  = 6;
    localparam int NOP = 3;
    localparam int DEP = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                          in_valid;
    logic [IDW-1:0]                in_inst_id;
    logic [NOP-1:0][PW-1:0]        in_prn;
    logic [NOP-1:0][63:0]          in_data;
    logic [NOP-1:0]                in_slot_valid;
    logic                          in_ready;
    logic                          wb_valid;
    logic [PW-1:0]                 wb_prn;
    logic [63:0]                   wb_data;
    logic                          wb_ready;
    logic                          done_valid;
    logic [IDW-1:0]                done_inst_id;

    fu_wb_serializer #(
        .INST_ID_BITS (IDW),
        .PRN_BITS     (PW),
        .MAX_OPERANDS (NOP),
        .DEPTH        (DEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_inst_id    (in_inst_id),
        .in_prn        (in_prn),
        .in_data       (in_data),
        .in_slot_valid (in_slot_valid),
        .in_ready      (in_ready),
        .wb_valid      (wb_valid),
        .wb_prn        (wb_prn),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .done_valid    (done_valid),
        .done_inst_id  (done_inst_id)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [PW+64-1:0] exp_q[$];
    logic [IDW-1:0]   exp_done_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [IDW-1:0] id, input logic [NOP-1:0] mask,
                              input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                              input logic [PW-1:0] p2, input logic [63:0] d0,
                              input logic [63:0] d1, input logic [63:0] d2);
        in_valid      = 1'b1;
        in_inst_id    = id;
        in_slot_valid = mask;
        in_prn[0]     = p0;
        in_prn[1]     = p1;
        in_prn[2]     = p2;
        in_data[0]    = d0;
        in_data[1]    = d1;
        in_data[2]    = d2;
    endtask

    task automatic expect_wr(input logic [PW-1:0] prn, input logic [63:0] data);
        exp_q.push_back({prn, data});
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 60 && (exp_q.size() != 0 || exp_done_q.size() != 0); c++) begin
            tick();
        end
        chk(tag, 64'(exp_q.size() + exp_done_q.size()), 64'd0);
        tick();
        tick();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {58'd0, wb_prn}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [PW+64-1:0] e;
                    e = exp_q.pop_front();
                    chk("wb_prn", {58'd0, wb_prn}, {58'd0, e[PW+64-1:64]});
                    chk("wb_data", wb_data, e[63:0]);
                end
            end
            if (done_valid) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", {58'd0, done_inst_id}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [IDW-1:0] ed;
                    ed = exp_done_q.pop_front();
                    chk("done_id", {58'd0, done_inst_id}, {58'd0, ed});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequences ----------------
    initial begin
        in_valid      = 1'b0;
        in_inst_id    = '0;
        in_prn        = '0;
        in_data       = '0;
        in_slot_valid = '0;
        wb_ready      = 1'b0;

        // Reset values.
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_prn", {58'd0, wb_prn}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_done", {63'd0, done_valid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_ready_after", {63'd0, in_ready}, 64'd1);

        // Three-slot bundle, wb_ready held high.
        wb_ready = 1'b1;
        set_bundle(6'd5, 3'b111, 6'd10, 6'd11, 6'd12, 64'hA, 64'hB, 64'hC);
        expect_wr(6'd10, 64'hA);
        expect_wr(6'd11, 64'hB);
        expect_wr(6'd12, 64'hC);
        exp_done_q.push_back(6'd5);
        @(negedge clk);
        chk("t1_ready", {63'd0, in_ready}, 64'd1);
        chk("t1_idle_valid", {63'd0, wb_valid}, 64'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat_valid", {63'd0, wb_valid}, 64'd1);
        chk("t1_prn0", {58'd0, wb_prn}, 64'd10);
        tick();
        @(negedge clk);
        chk("t1_prn1", {58'd0, wb_prn}, 64'd11);
        tick();
        @(negedge clk);
        chk("t1_prn2", {58'd0, wb_prn}, 64'd12);
        chk("t1_no_done_yet", {63'd0, done_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("t1_done", {63'd0, done_valid}, 64'd1);
        chk("t1_done_id", {58'd0, done_inst_id}, 64'd5);
        chk("t1_valid_low", {63'd0, wb_valid}, 64'd0);
        chk("t1_prn_zero", {58'd0, wb_prn}, 64'd0);
        chk("t1_data_zero", wb_data, 64'd0);
        tick();
        @(negedge clk);
        chk("t1_done_pulse", {63'd0, done_valid}, 64'd0);

        // Sparse mask 101 with wb_ready toggling 0,1,0,1.
        wb_ready = 1'b0;
        set_bundle(6'd7, 3'b101, 6'd3, 6'd5, 6'd9, 64'h33, 64'h55, 64'h99);
        expect_wr(6'd3, 64'h33);
        expect_wr(6'd9, 64'h99);
        exp_done_q.push_back(6'd7);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_stall_prn3", {58'd0, wb_prn}, 64'd3);
        chk("t2_stall_data3", wb_data, 64'h33);
        tick();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t2_held_prn3", {58'd0, wb_prn}, 64'd3);
        tick();
        wb_ready = 1'b0;
        @(negedge clk);
        chk("t2_stall_prn9", {58'd0, wb_prn}, 64'd9);
        chk("t2_stall_data9", wb_data, 64'h99);
        tick();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t2_held_prn9", {58'd0, wb_prn}, 64'd9);
        chk("t2_no_done_yet", {63'd0, done_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("t2_done", {63'd0, done_valid}, 64'd1);
        chk("t2_done_id", {58'd0, done_inst_id}, 64'd7);
        tick();
        @(negedge clk);
        chk("t2_single_done", {63'd0, done_valid}, 64'd0);

        // Zero-write bundle.
        set_bundle(6'd2, 3'b000, 6'd1, 6'd2, 6'd3, 64'h1, 64'h2, 64'h3);
        exp_done_q.push_back(6'd2);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_no_wb", {63'd0, wb_valid}, 64'd0);
        chk("t3_no_done_early", {63'd0, done_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("t3_done", {63'd0, done_valid}, 64'd1);
        chk("t3_done_id", {58'd0, done_inst_id}, 64'd2);
        chk("t3_no_wb2", {63'd0, wb_valid}, 64'd0);
        tick();

        // Fill with wb_ready low, fifth bundle is back-pressured.
        wb_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            set_bundle(IDW'(i), 3'b001, PW'(20 + i), 6'd0, 6'd0, 64'h100 + 64'(i), 64'd0, 64'd0);
            expect_wr(PW'(20 + i), 64'h100 + 64'(i));
            exp_done_q.push_back(IDW'(i));
            @(negedge clk);
            chk("t4_fill_ready", {63'd0, in_ready}, 64'd1);
            tick();
        end
        set_bundle(6'd4, 3'b001, 6'd24, 6'd0, 6'd0, 64'h104, 64'd0, 64'd0);
        expect_wr(6'd24, 64'h104);
        exp_done_q.push_back(6'd4);
        @(negedge clk);
        chk("t4_full", {63'd0, in_ready}, 64'd0);
        chk("t4_head_prn", {58'd0, wb_prn}, 64'd20);
        tick();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t4_still_full", {63'd0, in_ready}, 64'd0);
        chk("t4_head_prn2", {58'd0, wb_prn}, 64'd20);
        tick();
        @(negedge clk);
        chk("t4_reready", {63'd0, in_ready}, 64'd1);
        chk("t4_first_done", {63'd0, done_valid}, 64'd1);
        tick();
        in_valid = 1'b0;
        wait_drain("t4_drain");

        // Back-to-back single-slot bundles across pointer wrap.
        wb_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_bundle(IDW'(10 + k), 3'b001, PW'(30 + k), 6'd0, 6'd0, 64'h200 + 64'(k), 64'd0, 64'd0);
            expect_wr(PW'(30 + k), 64'h200 + 64'(k));
            exp_done_q.push_back(IDW'(10 + k));
            @(negedge clk);
            chk("t5_ready", {63'd0, in_ready}, 64'd1);
            chk("t5_count_le2", {63'd0, (dut.count <= 2)}, 64'd1);
            if (k > 0) chk("t5_sustained", {63'd0, wb_valid}, 64'd1);
            tick();
        end
        in_valid = 1'b0;
        wait_drain("t5_drain");

        // Reset in the middle of a three-slot drain.
        set_bundle(6'd9, 3'b111, 6'd40, 6'd41, 6'd42, 64'h40, 64'h41, 64'h42);
        expect_wr(6'd40, 64'h40);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_first_prn", {58'd0, wb_prn}, 64'd40);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("t6_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t6_rst_wb_prn", {58'd0, wb_prn}, 64'd0);
        chk("t6_rst_done", {63'd0, done_valid}, 64'd0);
        chk("t6_q_consumed", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("t6_no_done", {63'd0, done_valid}, 64'd0);
            chk("t6_no_wb", {63'd0, wb_valid}, 64'd0);
        end
        tick();
        set_bundle(6'd11, 3'b111, 6'd50, 6'd51, 6'd52, 64'h50, 64'h51, 64'h52);
        expect_wr(6'd50, 64'h50);
        expect_wr(6'd51, 64'h51);
        expect_wr(6'd52, 64'h52);
        exp_done_q.push_back(6'd11);
        @(negedge clk);
        chk("t6_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_slot0_first", {58'd0, wb_prn}, 64'd50);
        wait_drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
